// File: rtl/fx_operand_fetch_if.sv
// Signal bundle between fx_operand_fetch, dispatch, the FX register file and the FX execution unit.
// The master modport is the operand-fetch block's view; slave is everything around it.
interface fx_operand_fetch_if #(
  parameter int regSize           = 64,
  parameter int numGPRAddressBits = 6,
  parameter int tagBits           = 6
);
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [tagBits-1:0]           in_tag_i;
  logic [2:0]                   in_srcEn_i;
  logic [numGPRAddressBits-1:0] in_srcAddr1_i;
  logic [numGPRAddressBits-1:0] in_srcAddr2_i;
  logic [numGPRAddressBits-1:0] in_srcAddr3_i;
  logic                         in_raZero_i;

  logic                         gprRead1En_o;
  logic                         gprRead2En_o;
  logic                         gprRead3En_o;
  logic [numGPRAddressBits-1:0] gprReadAddr1_o;
  logic [numGPRAddressBits-1:0] gprReadAddr2_o;
  logic [numGPRAddressBits-1:0] gprReadAddr3_o;
  logic [regSize-1:0]           gprRead1_i;
  logic [regSize-1:0]           gprRead2_i;
  logic [regSize-1:0]           gprRead3_i;
  logic [regSize-1:0]           XER_i;

  logic                         gprWrite1En_i;
  logic                         gprWrite2En_i;
  logic                         gprWrite3En_i;
  logic                         gprWrite4En_i;
  logic [numGPRAddressBits-1:0] gprWriteAddr1_i;
  logic [numGPRAddressBits-1:0] gprWriteAddr2_i;
  logic [numGPRAddressBits-1:0] gprWriteAddr3_i;
  logic [numGPRAddressBits-1:0] gprWriteAddr4_i;
  logic [regSize-1:0]           gprWrite1Val_i;
  logic [regSize-1:0]           gprWrite2Val_i;
  logic [regSize-1:0]           gprWrite3Val_i;
  logic [regSize-1:0]           gprWrite4Val_i;

  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [tagBits-1:0]           out_tag_o;
  logic [regSize-1:0]           out_opA_o;
  logic [regSize-1:0]           out_opB_o;
  logic [regSize-1:0]           out_opS_o;
  logic [regSize-1:0]           out_XER_o;

  modport master (
    input  in_valid_i, in_tag_i, in_srcEn_i, in_srcAddr1_i, in_srcAddr2_i, in_srcAddr3_i, in_raZero_i,
    input  gprRead1_i, gprRead2_i, gprRead3_i, XER_i,
    input  gprWrite1En_i, gprWrite2En_i, gprWrite3En_i, gprWrite4En_i,
    input  gprWriteAddr1_i, gprWriteAddr2_i, gprWriteAddr3_i, gprWriteAddr4_i,
    input  gprWrite1Val_i, gprWrite2Val_i, gprWrite3Val_i, gprWrite4Val_i,
    input  out_ready_i,
    output in_ready_o,
    output gprRead1En_o, gprRead2En_o, gprRead3En_o,
    output gprReadAddr1_o, gprReadAddr2_o, gprReadAddr3_o,
    output out_valid_o, out_tag_o, out_opA_o, out_opB_o, out_opS_o, out_XER_o
  );

  modport slave (
    output in_valid_i, in_tag_i, in_srcEn_i, in_srcAddr1_i, in_srcAddr2_i, in_srcAddr3_i, in_raZero_i,
    output gprRead1_i, gprRead2_i, gprRead3_i, XER_i,
    output gprWrite1En_i, gprWrite2En_i, gprWrite3En_i, gprWrite4En_i,
    output gprWriteAddr1_i, gprWriteAddr2_i, gprWriteAddr3_i, gprWriteAddr4_i,
    output gprWrite1Val_i, gprWrite2Val_i, gprWrite3Val_i, gprWrite4Val_i,
    output out_ready_i,
    input  in_ready_o,
    input  gprRead1En_o, gprRead2En_o, gprRead3En_o,
    input  gprReadAddr1_o, gprReadAddr2_o, gprReadAddr3_o,
    input  out_valid_o, out_tag_o, out_opA_o, out_opB_o, out_opS_o, out_XER_o
  );
endinterface

// File: rtl/fx_operand_fetch.sv
// FX operand fetch: drives GPR read ports 1-3, tracks the fixed 3-edge read return and queues operands in order.
// Optional write-port bypass for writes landing at E1/E2 is enabled by defining FX_OPFETCH_BYPASS_EN.
module fx_operand_fetch #(
  parameter int regSize           = 64,
  parameter int numGPRAddressBits = 6,
  parameter int tagBits           = 6,
  parameter int outDepth          = 4,
  parameter int fxOpFetchInstance = 0
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               flush_i,
  fx_operand_fetch_if.master bus
);
  localparam int ptrW = $clog2(outDepth);
  localparam int cntW = ptrW + 1;

  if (outDepth < 4 || (outDepth & (outDepth - 1)) != 0 || fxOpFetchInstance < 0) begin : g_badConfig
    $error("fx_operand_fetch: outDepth must be a power of 2 >= 4 and instance >= 0");
  end

  typedef struct packed {
    logic                              valid;
    logic [tagBits-1:0]                tag;
    logic [2:0]                        srcUse;
    logic [2:0][numGPRAddressBits-1:0] addr;
`ifdef FX_OPFETCH_BYPASS_EN
    logic [2:0]                        hit;
    logic [2:0][regSize-1:0]           fwd;
`endif
  } PipeEntry;

  typedef struct packed {
    logic [tagBits-1:0]      tag;
    logic [2:0][regSize-1:0] op;
    logic [regSize-1:0]      xer;
  } FifoEntry;

  logic                              r_live;
  logic [cntW-1:0]                   r_inFlight;
  logic [cntW-1:0]                   r_fifoCount;
  logic [ptrW-1:0]                   r_rdPtr;
  logic [ptrW-1:0]                   r_wrPtr;
  logic                              r_outValid;
  FifoEntry                          r_head;
  FifoEntry                          r_mem [outDepth];
  PipeEntry                          r_pipe [3];
  logic [2:0]                        r_rdEn;
  logic [2:0][numGPRAddressBits-1:0] r_rdAddr;

  logic                              w_accept;
  logic                              w_push;
  logic                              w_pop;
  logic [2:0]                        w_inUse;
  logic [2:0][numGPRAddressBits-1:0] w_inAddr;
  logic [2:0][regSize-1:0]           w_rdData;
  logic [ptrW-1:0]                   w_nextRd;
  logic [cntW-1:0]                   w_nextCount;
  PipeEntry                          w_newEntry;
  PipeEntry                          w_snoop1;
  PipeEntry                          w_snoop2;
  FifoEntry                          w_pushEntry;
  FifoEntry                          w_nextHead;

  // Credits count both in-flight reads and queued bundles, so a push can never find the FIFO full.
  assign bus.in_ready_o = r_live && ((r_inFlight + r_fifoCount) < cntW'(outDepth));
  assign w_accept       = bus.in_valid_i && bus.in_ready_o && !flush_i;
  assign w_push         = r_pipe[2].valid;
  assign w_pop          = r_outValid && bus.out_ready_i;
  assign w_inAddr       = {bus.in_srcAddr3_i, bus.in_srcAddr2_i, bus.in_srcAddr1_i};
  assign w_inUse        = {bus.in_srcEn_i[2:1],
                           bus.in_srcEn_i[0] && !(bus.in_raZero_i && bus.in_srcAddr1_i == '0)};
  assign w_rdData       = {bus.gprRead3_i, bus.gprRead2_i, bus.gprRead1_i};
  assign w_nextRd       = r_rdPtr + ptrW'(w_pop);
  assign w_nextCount    = r_fifoCount + cntW'(w_push) - cntW'(w_pop);

  always_comb begin
    w_newEntry        = '0;
    w_newEntry.valid  = w_accept;
    w_newEntry.tag    = bus.in_tag_i;
    w_newEntry.srcUse = w_inUse;
    w_newEntry.addr   = w_inAddr;
  end

`ifdef FX_OPFETCH_BYPASS_EN
  logic [3:0]                        w_wrEn;
  logic [3:0][numGPRAddressBits-1:0] w_wrAddr;
  logic [3:0][regSize-1:0]           w_wrVal;

  assign w_wrEn   = {bus.gprWrite4En_i, bus.gprWrite3En_i, bus.gprWrite2En_i, bus.gprWrite1En_i};
  assign w_wrAddr = {bus.gprWriteAddr4_i, bus.gprWriteAddr3_i, bus.gprWriteAddr2_i, bus.gprWriteAddr1_i};
  assign w_wrVal  = {bus.gprWrite4Val_i, bus.gprWrite3Val_i, bus.gprWrite2Val_i, bus.gprWrite1Val_i};

  // Ports are scanned upward so the highest-numbered matching port wins, like the file's write order.
  always_comb begin
    w_snoop1 = r_pipe[0];
    w_snoop2 = r_pipe[1];
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < 4; p++) begin
        if (r_pipe[0].srcUse[s] && w_wrEn[p] && (w_wrAddr[p] == r_pipe[0].addr[s])) begin
          w_snoop1.hit[s] = 1'b1;
          w_snoop1.fwd[s] = w_wrVal[p];
        end
        if (r_pipe[1].srcUse[s] && w_wrEn[p] && (w_wrAddr[p] == r_pipe[1].addr[s])) begin
          w_snoop2.hit[s] = 1'b1;
          w_snoop2.fwd[s] = w_wrVal[p];
        end
      end
    end
  end
`else
  always_comb begin
    w_snoop1 = r_pipe[0];
    w_snoop2 = r_pipe[1];
  end
`endif

  always_comb begin
    w_pushEntry     = '0;
    w_pushEntry.tag = r_pipe[2].tag;
    w_pushEntry.xer = bus.XER_i;
    for (int s = 0; s < 3; s++) begin
      if (r_pipe[2].srcUse[s]) begin
`ifdef FX_OPFETCH_BYPASS_EN
        w_pushEntry.op[s] = r_pipe[2].hit[s] ? r_pipe[2].fwd[s] : w_rdData[s];
`else
        w_pushEntry.op[s] = w_rdData[s];
`endif
      end
    end
  end

  // The new head is the pushed bundle exactly when it lands in the slot the read pointer moves to.
  assign w_nextHead = (w_push && (w_nextRd == r_wrPtr)) ? w_pushEntry : r_mem[w_nextRd];

  always_ff @(posedge clock_i) begin
    if (w_push && !flush_i) begin
      r_mem[r_wrPtr] <= w_pushEntry;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_live      <= 1'b0;
      r_inFlight  <= '0;
      r_fifoCount <= '0;
      r_rdPtr     <= '0;
      r_wrPtr     <= '0;
      r_outValid  <= 1'b0;
      r_head      <= '0;
      r_rdEn      <= '0;
      r_rdAddr    <= '0;
      for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush_i) begin
        r_inFlight  <= '0;
        r_fifoCount <= '0;
        r_rdPtr     <= '0;
        r_wrPtr     <= '0;
        r_outValid  <= 1'b0;
        r_rdEn      <= '0;
        for (int i = 0; i < 3; i++) r_pipe[i] <= '0;
      end else begin
        r_inFlight  <= r_inFlight + cntW'(w_accept) - cntW'(w_push);
        r_fifoCount <= w_nextCount;
        r_rdPtr     <= w_nextRd;
        r_wrPtr     <= r_wrPtr + ptrW'(w_push);
        r_outValid  <= (w_nextCount != '0);
        if (w_nextCount != '0) r_head <= w_nextHead;
        r_rdEn      <= w_accept ? w_inUse : 3'b000;
        if (w_accept) r_rdAddr <= w_inAddr;
        r_pipe[0]   <= w_newEntry;
        r_pipe[1]   <= w_snoop1;
        r_pipe[2]   <= w_snoop2;
      end
    end
  end

  assign bus.gprRead1En_o   = r_rdEn[0];
  assign bus.gprRead2En_o   = r_rdEn[1];
  assign bus.gprRead3En_o   = r_rdEn[2];
  assign bus.gprReadAddr1_o = r_rdAddr[0];
  assign bus.gprReadAddr2_o = r_rdAddr[1];
  assign bus.gprReadAddr3_o = r_rdAddr[2];
  assign bus.out_valid_o    = r_outValid;
  assign bus.out_tag_o      = r_head.tag;
  assign bus.out_opA_o      = r_head.op[0];
  assign bus.out_opB_o      = r_head.op[1];
  assign bus.out_opS_o      = r_head.op[2];
  assign bus.out_XER_o      = r_head.xer;
endmodule
